// File: rtl/line_depacketizer.sv
// rtl/line_depacketizer.sv - parses video-line packets into 29-bit pixel FIFO words
module line_depacketizer #(
  parameter int PIXELS = 600,
  parameter int VLINES = 720
) (
  input  logic        i_clk_125M,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_rx_sop,
  input  logic        i_rx_eop,
  input  logic        i_fifo_full,
  output logic        o_fifo_wr,
  output logic [28:0] o_fifo_din,
  output logic        o_line_done,
  output logic [15:0] o_err_cnt,
  output logic [15:0] o_drop_cnt
);

  localparam int              PW       = $clog2(PIXELS);
  localparam logic [PW-1:0]   LAST_PIX = PW'(PIXELS - 1);
  localparam logic [10:0]     Y_LIMIT  = 11'(VLINES);
  localparam logic [15:0]     CNT_MAX  = 16'hFFFF;

  typedef enum logic [2:0] {IDLE, HDR1, PIX_Y, PIX_C, DROP} state_t;

  state_t        state;
  logic [1:0]    x_cnt;
  logic [2:0]    y_hi;
  logic [10:0]   y_cnt;
  logic [7:0]    y_byte;
  logic [PW-1:0] pix_cnt;

  logic [10:0]   y_new;
  logic [15:0]   err_next;
  logic [15:0]   drop_next;

  // Full line number once H1 arrives; saturating increments for the statistics counters
  assign y_new     = {y_hi, i_rx_data};
  assign err_next  = (o_err_cnt  == CNT_MAX) ? o_err_cnt  : o_err_cnt  + 16'd1;
  assign drop_next = (o_drop_cnt == CNT_MAX) ? o_drop_cnt : o_drop_cnt + 16'd1;

  // Packet parser FSM; write strobe and line_done are registered, so a word
  // appears on the FIFO port one cycle after its C byte is accepted
  always_ff @(posedge i_clk_125M) begin
    if (i_rst) begin
      state       <= IDLE;
      x_cnt       <= 2'd0;
      y_hi        <= 3'd0;
      y_cnt       <= 11'd0;
      y_byte      <= 8'd0;
      pix_cnt     <= '0;
      o_fifo_wr   <= 1'b0;
      o_fifo_din  <= 29'd0;
      o_line_done <= 1'b0;
      o_err_cnt   <= 16'd0;
      o_drop_cnt  <= 16'd0;
    end else begin
      o_fifo_wr   <= 1'b0;
      o_line_done <= 1'b0;
      if (i_rx_valid) begin
        if (i_rx_sop && i_rx_eop) begin
          // A one-byte packet can never be valid
          o_err_cnt <= err_next;
          state     <= IDLE;
        end else if (i_rx_sop) begin
          // Packets already counted (DROP) are not counted a second time when abandoned
          if (state != IDLE && state != DROP) begin
            o_err_cnt <= err_next;
          end
          x_cnt   <= i_rx_data[7:6];
          y_hi    <= i_rx_data[2:0];
          pix_cnt <= '0;
          state   <= HDR1;
        end else begin
          case (state)
            IDLE: begin
              state <= IDLE;
            end
            HDR1: begin
              if (i_rx_eop) begin
                o_err_cnt <= err_next;
                state     <= IDLE;
              end else if (y_new >= Y_LIMIT) begin
                o_err_cnt <= err_next;
                state     <= DROP;
              end else begin
                y_cnt   <= y_new;
                pix_cnt <= '0;
                state   <= PIX_Y;
              end
            end
            PIX_Y: begin
              if (i_rx_eop) begin
                o_err_cnt <= err_next;
                state     <= IDLE;
              end else begin
                y_byte <= i_rx_data;
                state  <= PIX_C;
              end
            end
            PIX_C: begin
              if (i_fifo_full) begin
                o_drop_cnt <= drop_next;
                state      <= i_rx_eop ? IDLE : DROP;
              end else begin
                o_fifo_wr  <= 1'b1;
                o_fifo_din <= {x_cnt, y_cnt, y_byte, i_rx_data};
                pix_cnt    <= pix_cnt + 1'b1;
                if (pix_cnt == LAST_PIX) begin
                  if (i_rx_eop) begin
                    o_line_done <= 1'b1;
                    state       <= IDLE;
                  end else begin
                    o_err_cnt <= err_next;
                    state     <= DROP;
                  end
                end else if (i_rx_eop) begin
                  o_err_cnt <= err_next;
                  state     <= IDLE;
                end else begin
                  state <= PIX_Y;
                end
              end
            end
            DROP: begin
              if (i_rx_eop) begin
                state <= IDLE;
              end
            end
            default: begin
              state <= IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule
